alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue stage directly upstream of the 64-bit ALU. Accepts decoded-instruction fields (ALUOp, funct7[5], funct3) plus two 64-bit operands over a valid/ready handshake. Translates the fields into the ALU's 4-bit control code and buffers up to two operations in a skid buffer. Presents `a`, `b` and `control` to the ALU from a register, so the ALU inputs are always glitch-free and stall-safe.

## Interface
- `DATA_W`, 64, operand width (`a`, `b`)
- `TAG_W`, 5, destination-register tag carried alongside the operation
- `CNT_W`, 16, width of the issued/illegal counters
- `clk` input 1: single clock; all state updates on its rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `in_valid` input 1: upstream operation valid
- `in_ready` output 1: stage can accept; registered
- `in_aluop` input 2: ALUOp from main control
- `in_funct7_5` input 1: instruction bit 30
- `in_funct3` input 3: instruction bits 14:12
- `in_a`, `in_b` input DATA_W: operands
- `in_tag` input TAG_W: destination tag
- `out_valid` output 1: operation presented to ALU is valid
- `out_ready` input 1: downstream (ALU/EX register) consumes this cycle
- `a`, `b` output DATA_W: ALU operands
- `control` output 4: ALU control code
- `out_tag` output TAG_W: tag of presented operation
- `out_illegal` output 1: presented operation decoded illegal
- `err` output 1: sticky, set on any accepted illegal operation
- `issued_cnt` output CNT_W: operations consumed downstream, saturating
- `illegal_cnt` output CNT_W: illegal operations accepted, saturating

## Operation
- Decode (combinational on `in_*`, registered on accept):
  - ALUOp 00 -> 0010 (ADD)
  - ALUOp 01 -> 0110 (SUB)
  - ALUOp 10:
    - funct7_5=0, funct3=000 -> 0010
    - funct7_5=1, funct3=000 -> 0110
    - funct3=111 -> 0000 (AND, funct7_5 ignored)
    - funct3=110 -> 0001 (OR, funct7_5 ignored)
  - ALUOp 11, or any other combination -> illegal: `control`=0000, `out_illegal`=1
- Illegal operations are forwarded normally. They are not dropped.
- Accept on `in_valid && in_ready`. Consume on `out_valid && out_ready`.
- Two-entry buffer: main register (drives outputs) and skid register.
- State machine:
  - EMPTY: accept -> ONE.
  - ONE: accept without consume -> TWO (new entry into skid). Consume without accept -> EMPTY. Accept with consume -> ONE (new entry into main).
  - TWO: `in_ready`=0. Consume -> ONE (skid moves into main). Accept is impossible in TWO.
- `in_ready` = (next state != TWO), registered.
- `out_valid` = state != EMPTY.
- Order is strictly preserved. Each operation is presented exactly once.
- Outputs hold stable while `out_valid && !out_ready`.
- `issued_cnt` increments on consume. `illegal_cnt` increments on accept of an illegal op. Both saturate at all-ones.

## Timing
- Reset (async assert, `rst_n`=0) sets:
  - state EMPTY, `in_ready`=1, `out_valid`=0
  - `a`=`b`=0, `control`=0000, `out_tag`=0, `out_illegal`=0
  - `err`=0, both counters 0
- Reset mid-operation discards both buffered entries immediately.
- Deassertion is used synchronously (two-flop synchronised externally). The first accept occurs on the first rising edge with `rst_n`=1.
- Latency: accepted at edge N -> visible on outputs with `out_valid`=1 after edge N (1 cycle).
- Throughput: 1 op/cycle while `out_ready`=1.
- `in_ready` falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Simultaneous accept and consume in ONE: main is replaced, skid stays empty, counters both update.
- Counter at max with increment: holds max.

## Configuration
- `ALU_ISSUE_NOR_EN` defined: ALUOp 10, funct7_5=1, funct3=100 decodes to 1100 (NOR), legal.
- `ALU_ISSUE_NOR_EN` undefined: that combination is illegal (`control`=0000, `out_illegal`=1, `err` set, `illegal_cnt` increments).

## Test plan
- Reset, then send ALUOp 10/funct7_5 0/funct3 111, `a`=30, `b`=20, `out_ready`=1 -> next cycle `control`=0000, `a`=30, `b`=20, `out_valid`=1, `issued_cnt`=1 after consume.
- Stream four ops back-to-back with `out_ready`=1 -> `control` sequence 0010, 0110, 0000, 0001 on consecutive cycles, `in_ready` stays 1.
- Hold `out_ready`=0 and offer three ops -> first presented, second in skid, `in_ready`=0 from the cycle after the second accept. Release `out_ready` -> ops emerge in order, `in_ready` returns to 1.
- ALUOp 11 with `in_tag`=7 -> `out_illegal`=1, `control`=0000, `out_tag`=7, `err`=1 sticky, `illegal_cnt`=1. Repeat with `ALU_ISSUE_NOR_EN` defined and funct3=100/funct7_5=1 -> `control`=1100, `out_illegal`=0.
- Assert `rst_n`=0 with TWO entries buffered -> outputs return to reset values asynchronously, `in_ready`=1, counters 0.
- Preload counters near saturation (force `issued_cnt`=0xFFFE), consume 3 ops -> `issued_cnt`=0xFFFF.

Source files
------------

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   Issue stage feeding the 64-bit ALU. Decodes ALUOp / funct7[5] / funct3
//   into the ALU's 4-bit control code and holds up to two operations in a
//   main + skid buffer. The ALU operands and control come straight from the
//   main register, so they are glitch-free and hold steady under stall.
//
//   Optional feature macro: ALU_ISSUE_NOR_EN
//     defined   -> ALUOp 10, funct7_5=1, funct3=100 decodes to NOR (1100)
//     undefined -> that combination is illegal
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_aluop, in_funct7_5, in_funct3   decode fields
//   in_a, in_b, in_tag                 operands and destination tag
//   out_valid/out_ready                downstream handshake
//   a, b, control, out_tag, out_illegal   presented operation
//   err              sticky: an illegal op has been accepted
//   issued_cnt       saturating count of consumed ops
//   illegal_cnt      saturating count of accepted illegal ops
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic              in_funct7_5,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        control,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic              err,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  // Entry layout: {a, b, control, tag, illegal}
  localparam int ENT_W = 2 * DATA_W + 4 + TAG_W + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_in_ready;
  logic [ENT_W-1:0]    r_main;
  logic [ENT_W-1:0]    r_skid;
  logic                r_err;
  logic [CNT_W-1:0]    r_issued_cnt;
  logic [CNT_W-1:0]    r_illegal_cnt;

  logic [3:0]          w_ctrl;
  logic                w_illegal;
  logic [ENT_W-1:0]    w_in_entry;
  logic                w_accept;
  logic                w_consume;

  // Field decode. Anything not explicitly listed falls through as illegal
  // with a zero control code; illegal ops still flow through the buffer.
  always_comb begin
    w_ctrl    = 4'b0000;
    w_illegal = 1'b1;
    case (in_aluop)
      2'b00: begin w_ctrl = 4'b0010; w_illegal = 1'b0; end
      2'b01: begin w_ctrl = 4'b0110; w_illegal = 1'b0; end
      2'b10: begin
        case (in_funct3)
          3'b000: begin
            w_ctrl    = in_funct7_5 ? 4'b0110 : 4'b0010;
            w_illegal = 1'b0;
          end
          3'b111: begin w_ctrl = 4'b0000; w_illegal = 1'b0; end
          3'b110: begin w_ctrl = 4'b0001; w_illegal = 1'b0; end
`ifdef ALU_ISSUE_NOR_EN
          3'b100: begin
            if (in_funct7_5) begin
              w_ctrl    = 4'b1100;
              w_illegal = 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_in_entry = {in_a, in_b, w_ctrl, in_tag, w_illegal};
  assign w_accept   = in_valid && r_in_ready;
  assign w_consume  = (r_state != S_EMPTY) && out_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_next = S_ONE;
      S_ONE: begin
        if (w_accept && !w_consume)      w_state_next = S_TWO;
        else if (!w_accept && w_consume) w_state_next = S_EMPTY;
      end
      S_TWO:   if (w_consume) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_EMPTY;
      r_in_ready    <= 1'b1;
      r_main        <= '0;
      r_skid        <= '0;
      r_err         <= 1'b0;
      r_issued_cnt  <= '0;
      r_illegal_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      // Registered ready: low exactly while the buffer will be full.
      r_in_ready <= (w_state_next != S_TWO);

      case (r_state)
        S_EMPTY: if (w_accept) r_main <= w_in_entry;
        S_ONE: begin
          // With a simultaneous consume the new op replaces main directly,
          // keeping the skid empty; otherwise it parks in the skid.
          if (w_accept && w_consume)       r_main <= w_in_entry;
          else if (w_accept && !w_consume) r_skid <= w_in_entry;
        end
        S_TWO:   if (w_consume) r_main <= r_skid;
        default: ;
      endcase

      if (w_consume && (r_issued_cnt != '1))
        r_issued_cnt <= r_issued_cnt + CNT_W'(1);

      if (w_accept && w_illegal) begin
        r_err <= 1'b1;
        if (r_illegal_cnt != '1)
          r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != S_EMPTY);
  assign a           = r_main[ENT_W-1 -: DATA_W];
  assign b           = r_main[ENT_W-1-DATA_W -: DATA_W];
  assign control     = r_main[TAG_W+4 -: 4];
  assign out_tag     = r_main[TAG_W:1];
  assign out_illegal = r_main[0];
  assign err         = r_err;
  assign issued_cnt  = r_issued_cnt;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_aluop = '0;
  logic        in_funct7_5 = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] a, b;
  logic [3:0]  control;
  logic [4:0]  out_tag;
  logic        out_illegal, err;
  logic [15:0] issued_cnt, illegal_cnt;

  // Second instance with tiny counters to reach saturation quickly.
  logic        s_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic [1:0]  s_aluop = 2'b11;
  logic [63:0] s_a, s_b;
  logic [3:0]  s_control;
  logic [4:0]  s_out_tag;
  logic        s_out_illegal, s_err;
  logic [1:0]  s_issued_cnt, s_illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(64), .TAG_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct7_5(in_funct7_5), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .a(a), .b(b), .control(control), .out_tag(out_tag),
    .out_illegal(out_illegal), .err(err), .issued_cnt(issued_cnt),
    .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.DATA_W(64), .TAG_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_aluop(s_aluop), .in_funct7_5(1'b0), .in_funct3(3'b000),
    .in_a(64'd1), .in_b(64'd2), .in_tag(5'd9), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .a(s_a), .b(s_b), .control(s_control),
    .out_tag(s_out_tag), .out_illegal(s_out_illegal), .err(s_err),
    .issued_cnt(s_issued_cnt), .illegal_cnt(s_illegal_cnt)
  );

  // Reference model: a FIFO of expected operations plus counters.
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  c;
    logic [4:0]  t;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   m_err, m_iss, m_ill;

  function automatic void ref_decode(input logic [1:0] op, input logic f7,
                                     input logic [2:0] f3,
                                     output logic [3:0] c, output logic ill);
    ill = 1'b0;
    if (op == 2'd0)                       c = 4'd2;
    else if (op == 2'd1)                  c = 4'd6;
    else if (op == 2'd2 && f3 == 3'd0)    c = f7 ? 4'd6 : 4'd2;
    else if (op == 2'd2 && f3 == 3'd7)    c = 4'd0;
    else if (op == 2'd2 && f3 == 3'd6)    c = 4'd1;
`ifdef ALU_ISSUE_NOR_EN
    else if (op == 2'd2 && f3 == 3'd4 && f7) c = 4'd12;
`endif
    else begin c = 4'd0; ill = 1'b1; end
  endfunction

  // Applies one cycle of stimulus (called just after a falling edge),
  // advances the model over the rising edge and returns at the next fall.
  task automatic drive(input logic v, input logic [1:0] op, input logic f7,
                       input logic [2:0] f3, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [4:0] tg,
                       input logic ordy);
    bit   acc, con;
    exp_t e;
    in_valid = v; in_aluop = op; in_funct7_5 = f7; in_funct3 = f3;
    in_a = aa; in_b = bb; in_tag = tg; out_ready = ordy;
    acc = v && (q.size() < 2);
    con = (q.size() > 0) && ordy;
    e.a = aa; e.b = bb; e.t = tg;
    ref_decode(op, f7, f3, e.c, e.ill);
    @(posedge clk);
    if (con) begin
      void'(q.pop_front());
      if (m_iss < 65535) m_iss++;
    end
    if (acc) begin
      q.push_back(e);
      if (e.ill) begin
        m_err = 1;
        if (m_ill < 65535) m_ill++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    q.delete(); m_err = 0; m_iss = 0; m_ill = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({a, b, control, out_tag, out_illegal} !== '0) begin errors++; $display("FAIL reset_outputs a=%h b=%h ctrl=%b tag=%0d ill=%b exp=all zero", a, b, control, out_tag, out_illegal); end
    checks++; if ({err, issued_cnt, illegal_cnt} !== '0) begin errors++; $display("FAIL reset_status err=%b iss=%0d ill=%0d exp=0", err, issued_cnt, illegal_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_and_example();
    do_reset();
    drive(1'b1, 2'b10, 1'b0, 3'b111, 64'd30, 64'd20, 5'd1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid got=%b exp=1", out_valid); end
    checks++; if (control !== 4'b0000) begin errors++; $display("FAIL and_control got=%b exp=0000", control); end
    checks++; if (a !== 64'd30 || b !== 64'd20) begin errors++; $display("FAIL and_operands a=%0d b=%0d exp=30,20", a, b); end
    drive(1'b0, 2'b00, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 1'b1);
    checks++; if (issued_cnt !== 16'd1) begin errors++; $display("FAIL and_issued got=%0d exp=1", issued_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_drained got=%b exp=0", out_valid); end
    $display("test_and_example done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops[4];
    logic [2:0] f3s[4];
    logic [3:0] exp_c[4];
    ops = '{2'b00, 2'b01, 2'b10, 2'b10};
    f3s = '{3'b000, 3'b000, 3'b111, 3'b110};
    exp_c = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 1'b0, f3s[i], 64'($urandom), 64'($urandom), 5'(i + 10), 1'b1);
      checks++; if (control !== exp_c[i] || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_control[%0d] got=%b valid=%b exp=%b valid=1", i, control, out_valid, exp_c[i]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
      checks++; if (out_tag !== 5'(i + 10)) begin errors++; $display("FAIL b2b_tag[%0d] got=%0d exp=%0d", i, out_tag, i + 10); end
    end
    drive(1'b0, 2'b00, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 1'b1);
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_tag[4];
    logic       exp_rdy[4];
    logic       exp_vld[4];
    exp_tag = '{5'd2, 5'd3, 5'd3, 5'd3};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_vld = '{1'b1, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 2'b00, 1'b0, 3'b000, 64'd11, 64'd1, 5'd1, 1'b0);
    checks++; if (in_ready !== 1'b1 || out_tag !== 5'd1) begin errors++; $display("FAIL bp_first rdy=%b tag=%0d exp=1,1", in_ready, out_tag); end
    drive(1'b1, 2'b01, 1'b0, 3'b000, 64'd22, 64'd2, 5'd2, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_tag !== 5'd1) begin errors++; $display("FAIL bp_full rdy=%b tag=%0d exp=0,1", in_ready, out_tag); end
    drive(1'b1, 2'b10, 1'b0, 3'b110, 64'd33, 64'd3, 5'd3, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_tag !== 5'd1 || a !== 64'd11) begin errors++; $display("FAIL bp_hold rdy=%b tag=%0d a=%0d exp=0,1,11", in_ready, out_tag, a); end
    // Release: op1 leaves, op2 moves up, then op3 is accepted, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 2'b10, 1'b0, 3'b110, 64'd33, 64'd3, 5'd3, 1'b1);
      checks++; if (out_valid !== exp_vld[i] || in_ready !== exp_rdy[i] || (exp_vld[i] && out_tag !== exp_tag[i])) begin errors++; $display("FAIL bp_release[%0d] valid=%b rdy=%b tag=%0d exp=%b,%b,%0d", i, out_valid, in_ready, out_tag, exp_vld[i], exp_rdy[i], exp_tag[i]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_illegal();
    logic [3:0] nor_c;
    logic       nor_ill;
`ifdef ALU_ISSUE_NOR_EN
    nor_c = 4'b1100; nor_ill = 1'b0;
`else
    nor_c = 4'b0000; nor_ill = 1'b1;
`endif
    do_reset();
    drive(1'b1, 2'b11, 1'b0, 3'b000, 64'd5, 64'd6, 5'd7, 1'b0);
    checks++; if (out_illegal !== 1'b1 || control !== 4'b0000 || out_tag !== 5'd7) begin errors++; $display("FAIL illegal_present ill=%b ctrl=%b tag=%0d exp=1,0000,7", out_illegal, control, out_tag); end
    checks++; if (err !== 1'b1 || illegal_cnt !== 16'd1) begin errors++; $display("FAIL illegal_status err=%b cnt=%0d exp=1,1", err, illegal_cnt); end
    drive(1'b0, 2'b00, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 1'b1);
    drive(1'b1, 2'b00, 1'b0, 3'b000, 64'd1, 64'd1, 5'd8, 1'b1);
    checks++; if (err !== 1'b1 || out_illegal !== 1'b0) begin errors++; $display("FAIL illegal_sticky err=%b ill=%b exp=1,0", err, out_illegal); end
    drive(1'b1, 2'b10, 1'b1, 3'b100, 64'd9, 64'd9, 5'd4, 1'b1);
    checks++; if (control !== nor_c || out_illegal !== nor_ill || out_tag !== 5'd4) begin errors++; $display("FAIL nor_decode ctrl=%b ill=%b tag=%0d exp=%b,%b,4", control, out_illegal, out_tag, nor_c, nor_ill); end
    checks++; if (illegal_cnt !== 16'(m_ill)) begin errors++; $display("FAIL nor_illegal_cnt got=%0d exp=%0d", illegal_cnt, m_ill); end
    drive(1'b0, 2'b00, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 1'b1);
    $display("test_illegal done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
            3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom), 1'($urandom_range(0, 9) < 6));
      checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_hs[%0d] valid=%b rdy=%b exp=%b,%b", i, out_valid, in_ready, q.size() > 0, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (a !== q[0].a || b !== q[0].b || control !== q[0].c || out_tag !== q[0].t || out_illegal !== q[0].ill) begin errors++; $display("FAIL rand_op[%0d] a=%h b=%h c=%b t=%0d i=%b exp a=%h b=%h c=%b t=%0d i=%b", i, a, b, control, out_tag, out_illegal, q[0].a, q[0].b, q[0].c, q[0].t, q[0].ill); end
      end
      checks++; if (err !== 1'(m_err) || issued_cnt !== 16'(m_iss) || illegal_cnt !== 16'(m_ill)) begin errors++; $display("FAIL rand_status[%0d] err=%b iss=%0d ill=%0d exp=%0d,%0d,%0d", i, err, issued_cnt, illegal_cnt, m_err, m_iss, m_ill); end
    end
    $display("test_random done: issued=%0d illegal=%0d", m_iss, m_ill);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b11, 1'b0, 3'b000, 64'd1, 64'd1, 5'd1, 1'b1);
    drive(1'b1, 2'b00, 1'b0, 3'b000, 64'd2, 64'd2, 5'd2, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 3'b000, 64'd3, 64'd3, 5'd3, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full rdy=%b valid=%b exp=0,1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_hs valid=%b rdy=%b exp=0,1", out_valid, in_ready); end
    checks++; if ({a, b, control, out_tag, out_illegal, err, issued_cnt, illegal_cnt} !== '0) begin errors++; $display("FAIL mid_reset_vals a=%h ctrl=%b tag=%0d err=%b iss=%0d ill=%0d exp=0", a, control, out_tag, err, issued_cnt, illegal_cnt); end
    @(negedge clk);
    q.delete(); m_err = 0; m_iss = 0; m_ill = 0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    $display("test_reset_mid done");
  endtask

  task automatic test_saturation();
    int ei, ec;
    do_reset();
    s_valid = 1'b1; s_out_ready = 1'b1; s_aluop = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); @(negedge clk);
      ei = (k > 3) ? 3 : k;
      ec = (k - 1 > 3) ? 3 : k - 1;
      checks++; if (s_illegal_cnt !== 2'(ei) || s_issued_cnt !== 2'(ec)) begin errors++; $display("FAIL sat[%0d] ill=%0d iss=%0d exp=%0d,%0d", k, s_illegal_cnt, s_issued_cnt, ei, ec); end
    end
    s_valid = 1'b0;
    $display("test_saturation done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_and_example();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
